// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and byte-lane indexing.
package fetch_pkg;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam int INSTR_BYTES = 4;

  typedef logic [1:0] lane_t;
endpackage

// File: rtl/fetch_byte_assembler.sv
// Builds a 32-bit big-endian word one byte at a time; lane 0 is the most significant byte.
module fetch_byte_assembler
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  lane_t       lane,
  input  logic [7:0]  data,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      case (lane)
        2'd0:    word[31:24] <= data;
        2'd1:    word[23:16] <= data;
        2'd2:    word[15:8]  <= data;
        default: word[7:0]   <= data;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks four ROM bytes per instruction, hands the word to
// decode over valid/ready, follows redirects and faults on fetches past the ROM end.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int ROM_BYTES     = 28,
  parameter int RESET_PC      = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [ADDRESS_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0]    rom_data_i,
  output logic [31:0]              instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     fetch_err_o
);

  state_e                   state_q, state_d;
  lane_t                    cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic                     valid_d, err_d, load;
  logic [ADDRESS_WIDTH:0]   last_byte;
  logic                     out_of_range;

  assign rom_addr_o = pc_o + ADDRESS_WIDTH'(cnt_q);

  // One extra bit so a PC near the top of the address space cannot wrap into range.
  assign last_byte    = {1'b0, pc_o} + (ADDRESS_WIDTH+1)'(INSTR_BYTES - 1);
  assign out_of_range = last_byte >= (ADDRESS_WIDTH+1)'(ROM_BYTES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_o;
    valid_d = instr_valid_o;
    err_d   = fetch_err_o;
    load    = 1'b0;

    case (state_q)
      FETCH: begin
        if (out_of_range) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else begin
          load  = 1'b1;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready_i) begin
          pc_d    = pc_o + ADDRESS_WIDTH'(INSTR_BYTES);
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // A redirect overrides everything; a same-cycle handshake still completes upstream.
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
      cnt_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      state_d = FETCH;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= FETCH;
      cnt_q         <= '0;
      pc_o          <= ADDRESS_WIDTH'(RESET_PC);
      instr_valid_o <= 1'b0;
      fetch_err_o   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pc_o          <= pc_d;
      instr_valid_o <= valid_d;
      fetch_err_o   <= err_d;
    end
  end

  fetch_byte_assembler u_asm (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (load),
    .lane (cnt_q),
    .data (rom_data_i[7:0]),
    .word (instr_o)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected instructions are queued at stimulus time and
// checked by a monitor at each accepted handshake; control/status checks are done inline.
module tb_fetch_sequencer;
  localparam int AW = 32;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, ready, redir, valid, err;
  logic [AW-1:0] rom_addr, pc, rpc;
  logic [7:0]    rom_data;
  logic [31:0]   instr;
  logic [7:0]    rom [0:27];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  assign rom_data = (rom_addr < 28) ? rom[rom_addr[4:0]] : 8'h00;

  fetch_sequencer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(8), .ROM_BYTES(28), .RESET_PC(0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .fetch_err_o   (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"}, 64'(pc), 64'h0);
    chk({tag, " valid"}, 64'(valid), 64'h0);
    chk({tag, " err"}, 64'(err), 64'h0);
    chk({tag, " instr"}, 64'(instr), 64'h0);
    chk({tag, " rom_addr"}, 64'(rom_addr), 64'h0);
  endtask

  // Scoreboard monitor: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_accept: got instr %0h pc %0h, expected none", instr, pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("accept instr", 64'(instr), 64'(e.instr));
        chk("accept pc", 64'(pc), 64'(e.pc));
      end
    end
  end

  initial begin
    rom[0] = 8'h00; rom[1] = 8'hA0; rom[2] = 8'h00; rom[3] = 8'h93;
    for (int i = 4; i < 28; i++) rom[i] = 8'(8'h40 + i);

    rst = 1'b1; ready = 1'b0; redir = 1'b0; rpc = '0;
    adv(); adv();
    smp(); chk_reset_vals("reset");

    // Release reset, ready held high: addresses 0..3, valid in cycle 4, then fetch at 4.
    adv(); rst = 1'b0; ready = 1'b1;
    exp_q.push_back('{instr: 32'h00A00093, pc: 0});
    for (int i = 0; i < 4; i++) begin
      smp(); chk("first fetch addr", 64'(rom_addr), 64'(i));
      chk("first fetch valid", 64'(valid), 64'h0);
      adv();
    end
    smp(); chk("valid cycle 4", 64'(valid), 64'h1);
    adv(); ready = 1'b0;
    smp(); chk("pc after accept", 64'(pc), 64'h4);
    chk("addr after accept", 64'(rom_addr), 64'h4);

    // Stall in HOLD for 10 cycles.
    adv(); adv(); adv(); adv();
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("hold valid", 64'(valid), 64'h1);
      chk("hold instr", 64'(instr), 64'h44454647);
      chk("hold pc", 64'(pc), 64'h4);
      chk("hold addr", 64'(rom_addr), 64'h4);
      adv();
    end
    ready = 1'b1;
    exp_q.push_back('{instr: 32'h44454647, pc: 4});
    smp();
    adv(); ready = 1'b0;
    smp(); chk("pc after stall", 64'(pc), 64'h8);

    // Redirect to 0xE at cnt=2: target aligned to 12, partial discarded.
    adv(); adv(); redir = 1'b1; rpc = 32'h0000000E;
    smp(); chk("addr at cnt2", 64'(rom_addr), 64'hA);
    adv(); redir = 1'b0;
    smp(); chk("redirect addr", 64'(rom_addr), 64'hC);
    chk("redirect pc", 64'(pc), 64'hC);
    chk("redirect valid", 64'(valid), 64'h0);
    adv(); adv(); adv(); adv();

    // Redirect coincident with acceptance: instruction delivered, PC from redirect.
    smp(); chk("valid before redir+accept", 64'(valid), 64'h1);
    adv(); ready = 1'b1; redir = 1'b1; rpc = 32'h8;
    exp_q.push_back('{instr: 32'h4C4D4E4F, pc: 12});
    smp();
    adv(); ready = 1'b0; redir = 1'b0;
    smp(); chk("redir+accept valid", 64'(valid), 64'h0);
    chk("redir+accept pc", 64'(pc), 64'h8);
    chk("redir+accept addr", 64'(rom_addr), 64'h8);

    // Stream 8..24 at full rate, then run off the end of the ROM.
    ready = 1'b1;
    exp_q.push_back('{instr: 32'h48494A4B, pc: 8});
    exp_q.push_back('{instr: 32'h4C4D4E4F, pc: 12});
    exp_q.push_back('{instr: 32'h50515253, pc: 16});
    exp_q.push_back('{instr: 32'h54555657, pc: 20});
    exp_q.push_back('{instr: 32'h58595A5B, pc: 24});
    for (int i = 0; i < 25; i++) adv();
    smp(); chk("pc at rom end", 64'(pc), 64'd28);
    chk("err before fault", 64'(err), 64'h0);
    chk("valid at rom end", 64'(valid), 64'h0);
    adv();
    smp(); chk("fault err", 64'(err), 64'h1);
    chk("fault valid", 64'(valid), 64'h0);
    adv(); adv(); adv();
    smp(); chk("fault err held", 64'(err), 64'h1);
    chk("fault valid held", 64'(valid), 64'h0);
    chk("fault pc held", 64'(pc), 64'd28);

    // Redirect out of FAULT to 0 and fetch normally.
    adv(); redir = 1'b1; rpc = '0;
    smp();
    adv(); redir = 1'b0;
    smp(); chk("fault cleared", 64'(err), 64'h0);
    chk("fault redirect pc", 64'(pc), 64'h0);
    exp_q.push_back('{instr: 32'h00A00093, pc: 0});
    adv(); adv(); adv(); adv();
    smp(); chk("refetch valid", 64'(valid), 64'h1);

    // Reset mid-FETCH at cnt=1.
    adv(); ready = 1'b0;
    adv(); rst = 1'b1;
    smp(); chk("addr at cnt1", 64'(rom_addr), 64'h5);
    adv();
    smp(); chk_reset_vals("reset mid-fetch");

    // Reset while in FAULT.
    adv(); rst = 1'b0; redir = 1'b1; rpc = 32'd28;
    adv(); redir = 1'b0;
    adv();
    smp(); chk("err before fault reset", 64'(err), 64'h1);
    adv(); rst = 1'b1;
    adv();
    smp(); chk_reset_vals("reset in fault");
    rst = 1'b0;

    adv();
    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the byte-wide instruction ROM. Starting from a program counter, it issues four consecutive byte addresses, assembles the bytes big-endian into a 32-bit instruction, and presents it to decode with a valid/ready handshake. It supports redirects from branch/jump resolution and stops with a fault when a fetch would run past the end of the ROM. It sits between the instruction ROM and the decode stage.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of PC and ROM byte address
- DATA_WIDTH, 8, ROM byte width (fixed at 8; other values unsupported)
- ROM_BYTES, 28, ROM size in bytes; valid byte addresses 0..ROM_BYTES-1
- RESET_PC, 0, PC loaded on reset

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- rom_addr_o  out  ADDRESS_WIDTH  ROM byte address, combinational from state
- rom_data_i  in  DATA_WIDTH  ROM byte, combinational read of rom_addr_o, same cycle
- instr_o  out  32  assembled instruction, registered
- pc_o  out  ADDRESS_WIDTH  address of instr_o / fetch in progress, registered
- instr_valid_o  out  1  instr_o holds a complete instruction
- instr_ready_i  in  1  decode accepts instr_o this cycle
- redirect_i  in  1  load new PC, discard fetch in progress
- redirect_pc_i  in  ADDRESS_WIDTH  redirect target
- fetch_err_o  out  1  fetch faulted (out-of-range address), registered

## Operation
- States: FETCH, HOLD, FAULT. Byte counter cnt (2 bits).
- Reset: state FETCH, pc_o=RESET_PC, cnt=0, instr_o=0, instr_valid_o=0, fetch_err_o=0.
- rom_addr_o = pc_o + cnt, in all states (don't-care contents outside FETCH).
- FETCH entry check: if pc_o + 3 >= ROM_BYTES (compare in ADDRESS_WIDTH+1 bits, no wrap), next state FAULT, fetch_err_o=1; no bytes captured.
- FETCH: each cycle capture rom_data_i into byte lane cnt: cnt 0 -> instr_o[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; cnt increments. At cnt==3 the edge writes the final lane, sets instr_valid_o=1, cnt=0, state HOLD.
- HOLD: instr_o, pc_o stable. If instr_ready_i: pc_o <= pc_o + 4 (modulo 2^ADDRESS_WIDTH), instr_valid_o <= 0, state FETCH. Otherwise hold indefinitely.
- FAULT: instr_valid_o=0, fetch_err_o=1, all else held; exits only via redirect or reset.
- Redirect (any state, highest priority below reset): pc_o <= {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00}, cnt=0, instr_valid_o=0, fetch_err_o=0, state FETCH. Partial lanes are discarded; instr_o contents are don't-care until next valid.
- Redirect with instr_valid_o && instr_ready_i same cycle: the handshake completes (decode keeps the instruction); the PC comes from the redirect, not pc_o+4.
- Reset during any state overrides redirect and handshake.

## Timing
- Fetch latency: 4 cycles in FETCH; instr_valid_o rises in the 5th cycle after FETCH entry.
- Accept to next fetch: the cycle after acceptance is FETCH cnt=0 at pc+4, so the best-case rate is one instruction per 5 cycles.
- Reset release: first ROM address RESET_PC is driven in the first cycle with rst_i low; valid in cycle 4 after release (counting from 0).
- Redirect: target byte 0 is addressed in the cycle after redirect_i.
- Fault: fetch_err_o asserts one cycle after the out-of-range FETCH entry.
- instr_valid_o never falls without acceptance except on redirect or reset.

## Structure
- Package fetch_pkg: state enum (FETCH, HOLD, FAULT), INSTR_BYTES=4, byte-lane index type.
- One sub-module: fetch_byte_assembler (lane-select register load of 8-bit byte into 32-bit word, clear on reset). FSM, PC and range check stay in fetch_sequencer.

## Test plan
- Reset, ROM bytes 0..3 = 00 A0 00 93, ready held 1 -> rom_addr_o 0,1,2,3; instr_o=32'h00A00093, pc_o=0, valid in cycle 4; next rom_addr_o=4.
- Ready held 0 for 10 cycles in HOLD -> instr_o, pc_o, valid stable, rom_addr_o fixed; ready=1 -> accepted, pc_o=4 next cycle.
- Redirect to 32'h0000000E at cnt=2 -> partial discarded, next rom_addr_o=12 (aligned), instr from bytes 12..15.
- Redirect same cycle as accept, target 8 -> valid falls, pc_o=8 (not pc+4).
- Sequential fetch to pc=24 with ROM_BYTES=28 succeeds (bytes 24..27); accept -> pc=28 -> fetch_err_o=1, valid stays 0; redirect to 0 clears the fault and fetches normally.
- rst_i asserted mid-FETCH (cnt=1) and while in FAULT -> all outputs return to reset values on the next edge.
